// File: rtl/uart_tx_buf.sv
// Byte FIFO feeding an 8N1/8N2 UART transmitter; tx_o falls two edges after a byte enters an idle, empty buffer.
// ready_o drops while the FIFO holds FIFO_DEPTH bytes; frames are sent back to back while bytes remain queued.
module uart_tx_buf #(
   parameter int CLK_DIV    = 1041,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       tx_o,
   output logic       busy_o,
   output logic [4:0] level_o
);
   localparam int              CW        = $clog2(CLK_DIV);
   localparam int              AW        = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0]   BAUD_LAST = CW'(CLK_DIV - 1);
   localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic [4:0]      DEPTH     = 5'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            line_busy_q, line_busy_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [4:0]      level_q, level_d;
   logic [7:0]      mem [FIFO_DEPTH];

   logic push;
   logic pop;
   logic baud_end;

   assign ready_o  = (level_q < DEPTH);
   assign push     = valid_i & ready_o;
   assign baud_end = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (level_q != 5'd0) begin
               pop     = 1'b1;
               shift_d = mem[rd_ptr_q];
               state_d = START;
            end
         end
         START: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == STOP_LAST) begin
                  bit_d = '0;
                  // Chain straight into the next start bit when more bytes wait.
                  if (level_q != 5'd0) begin
                     pop     = 1'b1;
                     shift_d = mem[rd_ptr_q];
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // The line trails the state register by one edge, so every bit keeps its full width.
      case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
      line_busy_d = (state_q != IDLE);

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q + {4'd0, push} - {4'd0, pop};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         tx_q        <= 1'b1;
         line_busy_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         line_busy_q <= line_busy_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !rst_i) begin
         mem[wr_ptr_q] <= data_i;
      end
   end

   assign tx_o    = tx_q;
   assign level_o = level_q;
   // line_busy_q covers the final stop cycle still on the line after the state returns to IDLE.
   assign busy_o  = line_busy_q | (state_q != IDLE) | (level_q != 5'd0);

endmodule
